// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressable data memory controller.
// Holds access-size codes, FSM states and the size/lane legality check.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Illegal size code or a lane offset that does not match the access size.
    function automatic logic size_lane_fault(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte mask / replicated write data,
// and load lane extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        wmask_o = 4'b0000;
        wdata_o = '0;
        case (size_i)
            SZ_BYTE: begin
                wmask_o = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                wmask_o = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                wmask_o = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                wmask_o = 4'b0000;
                wdata_o = '0;
            end
        endcase
    end

    always_comb begin
        sel_byte = rword_i[8*lane_i +: 8];
        sel_half = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
        rdata_o  = '0;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{sel_byte[7] & ~unsigned_i}}, sel_byte};
            SZ_HALF: rdata_o = {{16{sel_half[15] & ~unsigned_i}}, sel_half};
            SZ_WORD: rdata_o = rword_i;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory with configurable latency and valid/ready handshakes.
// Define DMEM_PERF_CNT_EN to add load/store/fault performance counters.
//   state   | meaning
//   ST_IDLE | ready for a request
//   ST_WAIT | latency countdown, access not yet performed
//   ST_RESP | response held until rsp_ready
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]       cnt_loads,
    output logic [31:0]       cnt_stores,
    output logic [31:0]       cnt_faults
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e             state_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_fault_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               wr_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               acc_wr;
    logic [1:0]         acc_size;
    logic               acc_uns;
    logic [ADDR_W-1:0]  acc_addr;
    logic               acc_fault;
    logic               accept;
    logic               do_access;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        rword;
    logic [3:0]         wmask;
    logic [31:0]        wdata_sh;
    logic [31:0]        rdata_ext;
    logic [31:0]        wbits;
    logic [31:0]        wword;

    // With LATENCY == 1 the access runs on the accept edge, so operands come
    // straight from the request port; otherwise from the latched copy.
    always_comb begin
        acc_wr   = wr_q;
        acc_size = size_q;
        acc_uns  = uns_q;
        acc_addr = addr_q;
        if (state_q == ST_IDLE) begin
            acc_wr   = req_write;
            acc_size = req_size;
            acc_uns  = req_unsigned;
            acc_addr = req_addr;
        end
    end

    always_comb begin
        accept    = req_valid && req_ready_q;
        do_access = ((state_q == ST_IDLE) && accept && (LATENCY == 1)) ||
                    ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));
        acc_fault = size_lane_fault(acc_size, acc_addr[1:0]) ||
                    ((acc_addr >> (IDX_W + 2)) != '0);
        idx       = acc_addr[IDX_W+1:2];
        rword     = mem_q[idx];
    end

    dmem_lane_align u_lane_align (
        .size_i     (acc_size),
        .unsigned_i (acc_uns),
        .lane_i     (acc_addr[1:0]),
        .wdata_i    (req_wdata_sel()),
        .rword_i    (rword),
        .wmask_o    (wmask),
        .wdata_o    (wdata_sh),
        .rdata_o    (rdata_ext)
    );

    logic [31:0] wdata_q;

    function automatic logic [31:0] req_wdata_sel();
        return (state_q == ST_IDLE) ? req_wdata : wdata_q;
    endfunction

    always_comb begin
        wbits = '0;
        for (int b = 0; b < 4; b++) begin
            wbits[8*b +: 8] = {8{wmask[b]}};
        end
        wword = (rword & ~wbits) | (wdata_sh & wbits);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_access && acc_wr && !acc_fault) begin
            mem_q[idx] <= wword;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] cnt_loads_q;
    logic [31:0] cnt_stores_q;
    logic [31:0] cnt_faults_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_loads_q  <= '0;
            cnt_stores_q <= '0;
            cnt_faults_q <= '0;
        end else if (do_access) begin
            if (acc_fault) begin
                cnt_faults_q <= cnt_faults_q + 32'd1;
            end else if (acc_wr) begin
                cnt_stores_q <= cnt_stores_q + 32'd1;
            end else begin
                cnt_loads_q <= cnt_loads_q + 32'd1;
            end
        end
    end

    assign cnt_loads  = cnt_loads_q;
    assign cnt_stores = cnt_stores_q;
    assign cnt_faults = cnt_faults_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        wr_q        <= req_write;
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q <= ST_RESP;
                        end else begin
                            cnt_q   <= CNT_W'(LATENCY - 1);
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
            if (do_access) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= (acc_wr || acc_fault) ? 32'd0 : rdata_ext;
                rsp_fault_q <= acc_fault;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule
